// File: rtl/gf180mcu_fd_sc_mcu9t5v0__preset_pkg.sv
// Shared definitions for the staggered preset sequencer.
//   state_t : sequencer states
//   NGRP_D, PW_D, REC_D : default group count, SETN pulse width, recovery length
package gf180mcu_fd_sc_mcu9t5v0__preset_pkg;

   localparam int NGRP_D = 4;
   localparam int PW_D   = 2;
   localparam int REC_D  = 2;

   typedef enum logic [2:0] {
      IDLE,
      QUIESCE,
      ASSERT,
      RECOVER,
      DONE
   } state_t;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__preset_ffs.sv
// Lowest-set-bit finder used to pick the next group to preset.
//   mask : candidate groups
//   idx  : index of the lowest set bit (0 when mask is empty)
//   any  : mask has at least one bit set
module gf180mcu_fd_sc_mcu9t5v0__preset_ffs
   import gf180mcu_fd_sc_mcu9t5v0__preset_pkg::*;
#(
   parameter  int NGRP = NGRP_D,
   localparam int IW   = (NGRP > 1) ? $clog2(NGRP) : 1
) (
   input  logic [NGRP-1:0] mask,
   output logic [IW-1:0]   idx,
   output logic            any
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      idx = '0;
      for (int i = NGRP - 1; i >= 0; i--) begin
         if (mask[i]) idx = IW'(i);
      end
   end

   assign any = |mask;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__preset_seq.sv
// Staggered preset sequencer for a bank of negative-edge set flops split into
// NGRP groups. On request it stops the bank clock, pulses each selected
// group's SETN low one group at a time, waits out recovery, then re-enables.
//   CLK      : block clock, rising edge
//   RST      : synchronous reset, active-high
//   REQ      : four-phase preset request
//   GRP_MASK : groups to preset, captured at accept
//   SETN     : per-group active-low set (registered)
//   CLK_EN   : bank clock enable (registered)
//   BUSY     : accept until ACK
//   ACK      : handshake acknowledge, held until REQ low
//
// state   | meaning
// IDLE    | waiting for REQ; outputs at rest
// QUIESCE | bank clock being stopped, no SETN low yet
// ASSERT  | SETN of the lowest pending group low for PW cycles
// RECOVER | all SETN released, clock held off for REC cycles
// DONE    | clock back on, ACK raised, waiting for REQ low
//
// Outputs are registered from the current state, so each state's effect
// appears one edge after the state is entered.
module gf180mcu_fd_sc_mcu9t5v0__preset_seq
   import gf180mcu_fd_sc_mcu9t5v0__preset_pkg::*;
#(
   parameter int NGRP = NGRP_D,
   parameter int PW   = PW_D,
   parameter int REC  = REC_D,
   parameter int CW   = 4
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            REQ,
   input  logic [NGRP-1:0] GRP_MASK,
   output logic [NGRP-1:0] SETN,
   output logic            CLK_EN,
   output logic            BUSY,
   output logic            ACK
);

   localparam int            IW     = (NGRP > 1) ? $clog2(NGRP) : 1;
   localparam logic [CW-1:0] PW_LD  = CW'(PW - 1);
   localparam logic [CW-1:0] REC_LD = CW'(REC - 1);

   state_t          state;
   logic [NGRP-1:0] pend;
   logic [NGRP-1:0] cur_oh;
   logic [NGRP-1:0] pend_clr;
   logic [IW-1:0]   cur_idx;
   logic            cur_any;
   logic [CW-1:0]   cnt;

   // The current group is always the lowest bit still pending.
   gf180mcu_fd_sc_mcu9t5v0__preset_ffs #(.NGRP(NGRP)) u_ffs (
      .mask (pend),
      .idx  (cur_idx),
      .any  (cur_any)
   );

   assign cur_oh   = NGRP'(1) << cur_idx;
   assign pend_clr = pend & ~cur_oh;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         pend   <= '0;
         cnt    <= '0;
         SETN   <= '1;
         CLK_EN <= 1'b1;
         BUSY   <= 1'b0;
         ACK    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (REQ) begin
                  pend  <= GRP_MASK;
                  BUSY  <= 1'b1;
                  state <= (|GRP_MASK) ? QUIESCE : DONE;
               end
            end
            QUIESCE: begin
               CLK_EN <= 1'b0;
               SETN   <= '1;
               if (cur_any) begin
                  cnt   <= PW_LD;
                  state <= ASSERT;
               end else begin
                  cnt   <= REC_LD;
                  state <= RECOVER;
               end
            end
            ASSERT: begin
               SETN <= ~cur_oh;
               if (cnt == '0) begin
                  // Hand straight over to the next group: no dead cycle.
                  pend <= pend_clr;
                  if (|pend_clr) begin
                     cnt <= PW_LD;
                  end else begin
                     cnt   <= REC_LD;
                     state <= RECOVER;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            RECOVER: begin
               SETN   <= '1;
               CLK_EN <= 1'b0;
               if (cnt == '0) state <= DONE;
               else           cnt   <= cnt - CW'(1);
            end
            DONE: begin
               SETN <= '1;
               // First cycle raises ACK; REQ is only looked at once ACK is up,
               // so an early REQ drop still gives a one-cycle ACK.
               if (!ACK) begin
                  ACK    <= 1'b1;
                  BUSY   <= 1'b0;
                  CLK_EN <= 1'b1;
               end else if (!REQ) begin
                  ACK   <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
